hazard_ctrl: RTL

- Pipeline control unit for the 5-stage core.
- Watches the ID, EX, MEM and WB stage register fields. Drives stall and flush enables for the PC, IF/ID, ID/EX and EX/MEM registers, and the operand-forwarding selects for the EX stage ALU inputs.
- Sequences multi-cycle mul/div operations in EX by holding the upstream pipeline until the result is ready.

---
 rtl/hazard_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline stall/flush/forwarding control with a mul/div EX sequencer.
// Define HAZARD_PERF_CNT_EN to add saturating stall_cycles/flush_events counters.
module hazard_ctrl #(
  parameter int MULDIV_LAT = 8,
  parameter int RW = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_uses_rt,
  input  logic [RW-1:0] ex_rs,
  input  logic [RW-1:0] ex_rt,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_memread,
  input  logic          ex_muldiv,
  input  logic [RW-1:0] mem_rd,
  input  logic          mem_regwrite,
  input  logic [RW-1:0] wb_rd,
  input  logic          wb_regwrite,
  input  logic          branch_taken,
  output logic          pc_stall,
  output logic          ifid_stall,
  output logic          idex_stall,
  output logic          ifid_flush,
  output logic          idex_flush,
  output logic          exmem_flush,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          md_busy,
  output logic          md_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   flush_events
`endif
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam bit MULTI = MULDIV_LAT > 1;
  localparam logic [7:0] LOAD = 8'(MULDIV_LAT - 2);
  state_t state;
  logic [7:0] cnt;
  logic ok, md_start, md_stall, lu;
  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] r);
    return (mem_regwrite && mem_rd != '0 && mem_rd == r) ? 2'b10 :
           (wb_regwrite && wb_rd != '0 && wb_rd == r) ? 2'b01 : 2'b00;
  endfunction
  // Branch aborts any mul/div in progress, so the sequencer only advances when ok.
  always_comb begin
    ok = !RST && !branch_taken;
    md_start = ok && MULTI && state == IDLE && ex_muldiv;
    md_stall = md_start || (ok && state == BUSY && cnt != 8'd0);
    lu = ok && !md_stall && ex_memread && ex_rd != '0 &&
         (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
    md_done = ok && (MULTI ? (state == BUSY && cnt == 8'd0) : ex_muldiv);
    md_busy = !RST && (state == BUSY || md_stall);
    pc_stall = md_stall || lu;
    ifid_stall = md_stall || lu;
    idex_stall = md_stall;
    ifid_flush = !ok;
    idex_flush = !ok || lu;
    exmem_flush = !ok || md_stall;
    fwd_a = RST ? 2'b00 : fwd_sel(ex_rs);
    fwd_b = RST ? 2'b00 : fwd_sel(ex_rt);
  end
  always_ff @(posedge CLK) begin
    if (!ok) begin
      state <= IDLE;
      cnt <= 8'd0;
    end else if (md_start) begin
      state <= BUSY;
      cnt <= LOAD;
    end else if (state == BUSY) begin
      state <= cnt == 8'd0 ? IDLE : BUSY;
      cnt <= cnt == 8'd0 ? cnt : cnt - 8'd1;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (pc_stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 32'd1;
      if (branch_taken && !(&flush_events)) flush_events <= flush_events + 32'd1;
    end
  end
`endif
endmodule
